// File: rtl/wb_test_mailbox_pkg.sv
// Shared definitions for the Wishbone test mailbox: register map, CTRL and
// STATUS bit positions, FSM encoding and the unsigned range-check helper.
package wb_test_mailbox_pkg;

   localparam logic [2:0] REG_CTRL      = 3'd0;
   localparam logic [2:0] REG_EXP_MIN   = 3'd1;
   localparam logic [2:0] REG_MAX       = 3'd2;
   localparam logic [2:0] REG_MEASURED  = 3'd3;
   localparam logic [2:0] REG_STATUS    = 3'd4;
   localparam logic [2:0] REG_NUM_TESTS = 3'd5;

   localparam int unsigned CTRL_CMP_EQ    = 32'd0;
   localparam int unsigned CTRL_CMP_RANGE = 32'd1;
   localparam int unsigned CTRL_DONE      = 32'd2;
   localparam int unsigned CTRL_CLEAR     = 32'd3;

   localparam int unsigned STAT_FAIL_LSB = 32'd16;
   localparam int unsigned STAT_BUSY     = 32'd29;
   localparam int unsigned STAT_FAILED   = 32'd30;
   localparam int unsigned STAT_PASSED   = 32'd31;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COMPARE  = 2'd1,
      ST_REPORT   = 2'd2,
      ST_FINISHED = 2'd3
   } state_e;

   function automatic logic in_range(input logic [31:0] lo,
                                     input logic [31:0] hi,
                                     input logic [31:0] val);
      return (val >= lo) && (val <= hi);
   endfunction

endpackage

// File: rtl/wb_test_mailbox_wdt.sv
// Watchdog down-counter for the test mailbox: reloads on reset or load,
// counts while enabled and flags expiry on its final counting cycle.
module wb_test_mailbox_wdt #(
   parameter logic [31:0] LOAD_VALUE = 32'd50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic expire
);

   logic [31:0] count_r;

   // Down-counter, parked at zero once exhausted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= LOAD_VALUE;
      end else if (load) begin
         count_r <= LOAD_VALUE;
      end else if (en && (count_r != 32'd0)) begin
         count_r <= count_r - 32'd1;
      end
   end

   // Flag on the last count so the forced failure lands LOAD_VALUE cycles after the load
   assign expire = en & ~load & (count_r <= 32'd1);

endmodule

// File: rtl/wb_test_mailbox.sv
// Wishbone self-check mailbox: hardware compare, test/fail counting and sticky
// pass/fail flags. Optional watchdog enabled by WB_TEST_MAILBOX_WATCHDOG_EN.
module wb_test_mailbox
   import wb_test_mailbox_pkg::*;
#(
   parameter logic [31:0] WATCHDOG_CYCLES = 32'd50_000_000,
   parameter int unsigned COUNT_W         = 16
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_n_i,
   input  logic [4:0]         wb_adr_i,
   input  logic [31:0]        wb_dat_i,
   output logic [31:0]        wb_dat_o,
   input  logic               wb_we_i,
   input  logic [3:0]         wb_sel_i,
   input  logic               wb_cyc_i,
   input  logic               wb_stb_i,
   output logic               wb_ack_o,
   output logic               test_passed_o,
   output logic               test_failed_o,
   output logic               result_valid_o,
   output logic               result_pass_o,
   output logic [COUNT_W-1:0] result_index_o
);

   localparam int unsigned TC_W = (COUNT_W < 32'd16) ? COUNT_W : 32'd16;
   localparam int unsigned FC_W = (COUNT_W < 32'd8)  ? COUNT_W : 32'd8;

   state_e               state_r, state_nxt_s;
   logic [2:0]           reg_sel_s;
   logic                 unused_adr_s;
   logic                 busy_s, req_s, stall_s, accept_s, wr_s, ctrl_wr_s;
   logic                 cmd_clear_s, cmd_done_s, cmd_eq_s, cmd_range_s;
   logic                 start_cmp_s, report_s, done_s, done_ok_s;
   logic                 wdt_expire_s;
   logic                 ack_r, result_valid_r, result_pass_r;
   logic                 passed_r, failed_r, cmp_range_r, cmp_pass_r;
   logic [31:0]          dat_r, rd_data_s, status_s;
   logic [31:0]          exp_min_r, max_r, measured_r, num_tests_r;
   logic [COUNT_W-1:0]   test_count_r, fail_count_r, result_index_r;

   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
      if (&v) begin
         return v;
      end else begin
         return v + COUNT_W'(1);
      end
   endfunction

   assign reg_sel_s    = wb_adr_i[4:2];
   assign unused_adr_s = ^wb_adr_i[1:0];
   assign busy_s       = (state_r == ST_COMPARE) || (state_r == ST_REPORT);
   assign req_s        = wb_cyc_i & wb_stb_i & ~ack_r;
   assign stall_s      = req_s & wb_we_i & (reg_sel_s == REG_CTRL) & busy_s;
   assign accept_s     = req_s & ~stall_s;
   assign wr_s         = accept_s & wb_we_i & (wb_sel_i == 4'hF);
   assign ctrl_wr_s    = wr_s & (reg_sel_s == REG_CTRL);

   // Only the highest-priority CTRL bit produces a command
   assign cmd_clear_s  = ctrl_wr_s & wb_dat_i[CTRL_CLEAR];
   assign cmd_done_s   = ctrl_wr_s & ~wb_dat_i[CTRL_CLEAR] & wb_dat_i[CTRL_DONE];
   assign cmd_eq_s     = ctrl_wr_s & ~wb_dat_i[CTRL_CLEAR] & ~wb_dat_i[CTRL_DONE]
                         & wb_dat_i[CTRL_CMP_EQ];
   assign cmd_range_s  = ctrl_wr_s & ~wb_dat_i[CTRL_CLEAR] & ~wb_dat_i[CTRL_DONE]
                         & ~wb_dat_i[CTRL_CMP_EQ] & wb_dat_i[CTRL_CMP_RANGE];

   assign done_ok_s = (32'(test_count_r) == num_tests_r)
                      && (fail_count_r == {COUNT_W{1'b0}}) && !failed_r;

`ifdef WB_TEST_MAILBOX_WATCHDOG_EN
   wb_test_mailbox_wdt #(
      .LOAD_VALUE (WATCHDOG_CYCLES)
   ) u_wdt (
      .clk    (wb_clk_i),
      .rst_n  (wb_rst_n_i),
      .load   (cmd_clear_s),
      .en     (state_r != ST_FINISHED),
      .expire (wdt_expire_s)
   );
`else
   logic [31:0] unused_wdt_s;
   assign unused_wdt_s = WATCHDOG_CYCLES;
   assign wdt_expire_s = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state: CLEAR beats watchdog expiry, which beats normal flow
   always_comb begin
      state_nxt_s = state_r;
      if (cmd_clear_s) begin
         state_nxt_s = ST_IDLE;
      end else if (wdt_expire_s) begin
         state_nxt_s = ST_FINISHED;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (cmd_done_s) begin
                  state_nxt_s = ST_FINISHED;
               end else if (cmd_eq_s || cmd_range_s) begin
                  state_nxt_s = ST_COMPARE;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_COMPARE:  state_nxt_s = ST_REPORT;
            ST_REPORT:   state_nxt_s = ST_IDLE;
            ST_FINISHED: state_nxt_s = ST_FINISHED;
            default:     state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // FSM output decode
   always_comb begin
      start_cmp_s = 1'b0;
      report_s    = 1'b0;
      done_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            start_cmp_s = (state_nxt_s == ST_COMPARE);
            done_s      = cmd_done_s & ~wdt_expire_s;
         end
         ST_REPORT: report_s = (state_nxt_s == ST_IDLE);
         default: begin
            start_cmp_s = 1'b0;
            report_s    = 1'b0;
            done_s      = 1'b0;
         end
      endcase
   end

   // STATUS word assembly
   always_comb begin
      status_s                        = 32'd0;
      status_s[TC_W-1:0]              = test_count_r[TC_W-1:0];
      status_s[STAT_FAIL_LSB +: FC_W] = fail_count_r[FC_W-1:0];
      status_s[STAT_BUSY]             = busy_s;
      status_s[STAT_FAILED]           = failed_r;
      status_s[STAT_PASSED]           = passed_r;
   end

   // Read mux
   always_comb begin
      rd_data_s = 32'd0;
      case (reg_sel_s)
         REG_EXP_MIN:   rd_data_s = exp_min_r;
         REG_MAX:       rd_data_s = max_r;
         REG_MEASURED:  rd_data_s = measured_r;
         REG_STATUS:    rd_data_s = status_s;
         REG_NUM_TESTS: rd_data_s = num_tests_r;
         default:       rd_data_s = 32'd0;
      endcase
   end

   // Bus handshake, read data and data registers
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         ack_r          <= 1'b0;
         dat_r          <= 32'd0;
         result_valid_r <= 1'b0;
         exp_min_r      <= 32'd0;
         max_r          <= 32'd0;
         measured_r     <= 32'd0;
         num_tests_r    <= 32'd0;
      end else begin
         ack_r          <= accept_s;
         dat_r          <= (accept_s && !wb_we_i) ? rd_data_s : 32'd0;
         result_valid_r <= report_s;
         if (wr_s && (reg_sel_s == REG_EXP_MIN))   exp_min_r   <= wb_dat_i;
         if (wr_s && (reg_sel_s == REG_MAX))       max_r       <= wb_dat_i;
         if (wr_s && (reg_sel_s == REG_MEASURED))  measured_r  <= wb_dat_i;
         if (wr_s && (reg_sel_s == REG_NUM_TESTS)) num_tests_r <= wb_dat_i;
      end
   end

   // Compare mode capture and outcome register
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         cmp_range_r <= 1'b0;
         cmp_pass_r  <= 1'b0;
      end else begin
         if (start_cmp_s) cmp_range_r <= cmd_range_s;
         if (state_r == ST_COMPARE) begin
            cmp_pass_r <= cmp_range_r ? in_range(exp_min_r, max_r, measured_r)
                                      : (measured_r == exp_min_r);
         end
      end
   end

   // Test/fail counters and per-compare result outputs
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         test_count_r   <= {COUNT_W{1'b0}};
         fail_count_r   <= {COUNT_W{1'b0}};
         result_pass_r  <= 1'b0;
         result_index_r <= {COUNT_W{1'b0}};
      end else if (cmd_clear_s) begin
         test_count_r <= {COUNT_W{1'b0}};
         fail_count_r <= {COUNT_W{1'b0}};
      end else if (report_s) begin
         test_count_r   <= sat_inc(test_count_r);
         result_pass_r  <= cmp_pass_r;
         result_index_r <= test_count_r;
         if (!cmp_pass_r) fail_count_r <= sat_inc(fail_count_r);
      end
   end

   // Sticky flags; any failure source clears a previous pass
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         passed_r <= 1'b0;
         failed_r <= 1'b0;
      end else if (cmd_clear_s) begin
         passed_r <= 1'b0;
         failed_r <= 1'b0;
      end else if (wdt_expire_s || (report_s && !cmp_pass_r) || (done_s && !done_ok_s)) begin
         passed_r <= 1'b0;
         failed_r <= 1'b1;
      end else if (done_s) begin
         passed_r <= 1'b1;
      end
   end

   assign wb_ack_o       = ack_r;
   assign wb_dat_o       = dat_r;
   assign test_passed_o  = passed_r;
   assign test_failed_o  = failed_r;
   assign result_valid_o = result_valid_r;
   assign result_pass_o  = result_pass_r;
   assign result_index_o = result_index_r;

endmodule

// File: doc/wb_test_mailbox.md
# wb_test_mailbox

Synthesizable Wishbone slave through which firmware on the platform CPU reports self-check results to the simulation environment. Software writes expected/measured (or min/max/measured) values, triggers a compare, and finally declares completion. The block performs the comparison in hardware, counts tests and failures, and drives sticky pass/fail outputs that the testbench monitors to end simulation. It sits on the platform Wishbone bus alongside the other peripherals and is the producer side of the testbench pass/fail reporting path.

## Interface

Parameters:

- WATCHDOG_CYCLES, 32'd50_000_000, cycles from reset/clear with no completion before forced failure.
- COUNT_W, 16, width of the test and fail counters.

Ports:

- wb_clk_i  in  1  bus clock; all logic is in this domain.
- wb_rst_n_i  in  1  asynchronous active-low reset.
- wb_adr_i  in  5  byte address; bits [4:2] select the register.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, valid while wb_ack_o is high.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  4  byte selects; only full-word writes (4'hF) update registers.
- wb_cyc_i, wb_stb_i  in  1 each  bus cycle and strobe.
- wb_ack_o  out  1  transfer acknowledge.
- test_passed_o  out  1  sticky pass flag.
- test_failed_o  out  1  sticky fail flag.
- result_valid_o  out  1  one-cycle pulse per completed compare.
- result_pass_o  out  1  outcome of that compare; qualified by result_valid_o.
- result_index_o  out  COUNT_W  test number of that compare (pre-increment count).

## Operation

Register map (word offsets):

- 0x00 CTRL (W): bit0 CMP_EQ, bit1 CMP_RANGE, bit2 DONE, bit3 CLEAR. Reads return 0.
- 0x04 EXP_MIN (R/W): expected value, or range minimum.
- 0x08 MAX (R/W): range maximum.
- 0x0C MEASURED (R/W).
- 0x10 STATUS (RO): [15:0] test_count, [23:16] fail_count (low 8 bits), [29] busy, [30] failed, [31] passed.
- 0x14 NUM_TESTS (R/W): expected number of tests.
- 0x18, 0x1C: read 0, writes ignored.

Comparisons:

- CMP_EQ: pass iff MEASURED == EXP_MIN.
- CMP_RANGE: pass iff EXP_MIN <= MEASURED <= MAX, unsigned.

CTRL bits take effect in this priority: CLEAR > DONE > CMP_EQ > CMP_RANGE. Only the highest-priority set bit is acted on.

FSM states: IDLE, COMPARE, REPORT, FINISHED.

- IDLE -> COMPARE on an acked CTRL write with CMP_EQ or CMP_RANGE set.
- COMPARE -> REPORT: registers the outcome.
- REPORT -> IDLE: pulses result_valid_o; increments test_count (saturating); increments fail_count (saturating) on failure. The first failing compare sets test_failed_o.
- IDLE -> FINISHED on DONE. Sets test_passed_o iff test_count == NUM_TESTS and fail_count == 0 and test_failed_o is clear; otherwise sets test_failed_o.
- CLEAR from any state -> IDLE. Zeroes the counters and both flags and restarts the watchdog. Data registers and NUM_TESTS are kept.

In FINISHED, compare and DONE triggers are acked and ignored. test_passed_o and test_failed_o are never both high; a failure overrides and clears a pass.

## Timing

- Reset: wb_ack_o, wb_dat_o, test_passed_o, test_failed_o, result_valid_o, result_pass_o, result_index_o, all counters and all registers = 0. State = IDLE.
- wb_ack_o is registered. It rises the cycle after cyc & stb are seen with ack low, and is high for exactly one cycle per request. Back-to-back requests therefore complete every 2 cycles.
- Register writes take effect on the ack edge. Reads return the value at the ack edge.
- A CTRL write arriving while busy (COMPARE/REPORT) has its ack held off until the FSM returns to IDLE.
- Compare latency: result_valid_o is high 2 cycles after the CTRL ack. STATUS reflects the new counts on the cycle after result_valid_o.
- Reset mid-compare discards the compare with no pulse.
- Counters saturate at all-ones and do not wrap.

## Configuration

- WB_TEST_MAILBOX_WATCHDOG_EN defined: a 32-bit down-counter loads WATCHDOG_CYCLES at reset and on CLEAR. It decrements while not in FINISHED. On reaching 0 it forces test_failed_o = 1 and state FINISHED.
- Not defined: no watchdog logic. Only software DONE can finish the test.

## Structure

- Shared package wb_test_mailbox_pkg: register offsets, CTRL bit positions, STATUS field positions, FSM state encoding.
- One sub-module, wb_test_mailbox_wdt: the watchdog counter with load/enable/expire. It is instantiated only under the macro.

## Test plan

- NUM_TESTS = 2; CMP_EQ with 0x1234/0x1234, then CMP_RANGE with 5..10 / 7, then DONE -> two result_valid_o pulses with pass = 1, indices 0 and 1, then test_passed_o = 1 and STATUS = 0x8000_0002.
- CMP_EQ with expected 0xDEAD_BEEF, measured 0xDEAD_BEEE -> result_pass_o = 0, test_failed_o = 1 two cycles after ack. A following DONE keeps passed = 0.
- NUM_TESTS = 3, one passing compare, then DONE -> test_failed_o = 1, STATUS[15:0] = 1.
- Range boundaries: min = max = 0xFFFF_FFFF with measured equal -> pass. Measured = min - 1 -> fail.
- Back-to-back CTRL write issued during COMPARE -> its ack is delayed until IDLE. Both compares are counted; CLEAR then zeroes STATUS.
- With the macro and WATCHDOG_CYCLES = 100, no DONE written -> test_failed_o rises 100 cycles after reset. Without the macro -> it stays 0.
